// File: rtl/slow_clk_pkg.sv
// slow_clk_pkg: shared state encoding and default sizing for the slow clock monitor.
package slow_clk_pkg;
    typedef enum logic [1:0] {ACQUIRE, MEASURE, LOCKED, STALLED} mon_state_t;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF = 16;
    localparam int TIMEOUT_DEF = 1023;
endpackage

// File: rtl/level_sync.sv
// level_sync: multi-flop synchronizer for an asynchronous level, with a fill flag that
// marks when the output reflects a real sample rather than the reset value.
module level_sync
    import slow_clk_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic vld
);
    logic [STAGES-1:0] chain;
    logic [STAGES-1:0] fill;
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
            fill  <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            fill  <= {fill[STAGES-2:0], 1'b1};
        end
    end
    assign q   = chain[STAGES-1];
    assign vld = fill[STAGES-1];
endmodule

// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor: edge pulses, lock and stall status for the divided game clock.
// Defining PERIOD_CAPTURE_EN adds period_o, the rise-to-rise interval in clk_i cycles.
module slow_clk_monitor
    import slow_clk_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             slow_i,
    output logic             tick_o,
    output logic             fall_o,
    output logic             locked_o,
    output logic             stall_o
`ifdef PERIOD_CAPTURE_EN
    ,
    output logic [CNT_W-1:0] period_o
`endif
);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             lvl;
    logic             lvl_vld;
    logic             prev;
    logic             armed;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] gap;
    mon_state_t       state;
    mon_state_t       state_nxt;

    level_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk_i),
        .reset_n(reset_n),
        .d      (slow_i),
        .q      (lvl),
        .vld    (lvl_vld)
    );

    // Arming waits for a genuine low sample so the reset value of the chain never fakes a rise.
    assign rise = armed & lvl & ~prev;
    assign fall = armed & ~lvl & prev;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            prev   <= 1'b0;
            armed  <= 1'b0;
            tick_o <= 1'b0;
            fall_o <= 1'b0;
            gap    <= '0;
        end else begin
            prev   <= lvl;
            armed  <= armed | (lvl_vld & ~lvl);
            tick_o <= rise;
            fall_o <= fall;
            gap    <= (rise | fall) ? '0 : (gap == CNT_MAX ? gap : gap + CNT_W'(1));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) state <= ACQUIRE;
        else          state <= state_nxt;
    end

    // An edge on the timeout cycle takes priority, so the stall is never entered.
    always_comb begin
        state_nxt = state;
        if (rise)
            state_nxt = (state == MEASURE || state == LOCKED) ? LOCKED : MEASURE;
        else if (!fall && state != STALLED && gap == TIMEOUT_C)
            state_nxt = STALLED;
    end

    always_comb begin
        locked_o = (state == LOCKED);
        stall_o  = (state == STALLED);
    end

`ifdef PERIOD_CAPTURE_EN
    logic [CNT_W-1:0] per_cnt;
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt  <= '0;
            period_o <= '0;
        end else begin
            per_cnt <= rise ? CNT_W'(1) : (per_cnt == CNT_MAX ? per_cnt : per_cnt + CNT_W'(1));
            if (rise && state != ACQUIRE) period_o <= per_cnt;
        end
    end
`endif
endmodule
